// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifq_pkg
// Brief    : Shared types and helpers for the instruction prefetch queue.
// Revision : 1.0
// ============================================================================
package ifq_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } ifq_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    // Sequential successor address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifq_fifo
// Brief    : Small {pc, instr} FIFO with flush; wrap-bit pointers.
// Revision : 1.0
// ============================================================================
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output ifq_entry_t               head,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    ifq_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // A push into a full queue is legal only when the head leaves the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head      = r_mem[r_rd_ptr[AW-1:0]];
    assign occupancy = r_wr_ptr - r_rd_ptr;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Sequential instruction prefetch with redirect flush/drain.
//            Optional macro IFQ_BYPASS_EN: empty-queue response bypass.
// Revision : 1.0
// ============================================================================
module if_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam int            AW           = $clog2(DEPTH);
    localparam logic [AW+1:0] c_depth      = (AW + 2)'(DEPTH);
    localparam logic [31:0]   c_align_mask = 32'hFFFF_FFFC;

    ifq_state_t    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_drain_addr;

    ifq_entry_t    w_head;
    ifq_entry_t    w_push_data;
    logic [AW:0]   w_occ;
    logic [AW+1:0] w_occ_next;
    logic          w_full;
    logic          w_empty;
    logic          w_fetch_ack;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_space_next;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_id_pc;
    logic [31:0]   w_id_instr;

    assign w_redirect_pc = redirect_pc & c_align_mask;
    assign w_fetch_ack   = imem_ack && (r_state == FETCH) && !redirect;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_fetch_ack && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response consumed downstream never enters the queue.
    assign w_push       = w_fetch_ack && !(w_bypass && id_ready) && (!w_full || w_pop);
    assign w_pop        = !redirect && !w_empty && id_ready;
    assign w_occ_next   = (AW + 2)'(w_occ) + (AW + 2)'(w_push) - (AW + 2)'(w_pop);
    assign w_space_next = (w_occ_next < c_depth);

    assign w_push_data.pc    = r_fetch_pc;
    assign w_push_data.instr = imem_rdata;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect),
        .head      (w_head),
        .occupancy (w_occ),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        // Without an ack the old request is still in flight and must be drained.
                        if (!imem_ack) begin
                            r_drain_addr <= r_fetch_pc;
                            r_state      <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_fetch_pc <= pc_next(r_fetch_pc);
                        r_state    <= w_space_next ? FETCH : HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_state    <= FETCH;
                    end else if (w_space_next) begin
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                    if (imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req  = !rst && (r_state != HOLD);
    assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_fetch_pc;

    always_comb begin
        w_id_pc    = '0;
        w_id_instr = '0;
        if (w_bypass) begin
            w_id_pc    = r_fetch_pc;
            w_id_instr = imem_rdata;
        end else if (!w_empty) begin
            w_id_pc    = w_head.pc;
            w_id_instr = w_head.instr;
        end
    end

    assign id_valid = !redirect && (!w_empty || w_bypass);
    assign id_pc    = w_id_pc;
    assign id_instr = w_id_instr;
    assign id_pc4   = pc_next(w_id_pc);

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_queue
// Brief    : Randomised memory/IF-ID stimulus with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_if_prefetch_queue;
    import ifq_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    ifq_entry_t exp_q[$];
    bit         vis      = 1'b0;
    bit         mon_en   = 1'b0;
    bit         done     = 1'b0;

    // Reference model: next expected fetch address, entries held inside the DUT,
    // and whether the next memory response belongs to a cancelled fetch.
    logic [31:0] m_pc;
    int          m_occ;
    bit          m_drop;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_lat;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; id_ready = 1'b0; mon_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check32("rst_imem_req",  {31'b0, imem_req}, 32'd0);
        check32("rst_imem_addr", imem_addr, RESET_PC);
        check32("rst_id_valid",  {31'b0, id_valid}, 32'd0);
        check32("rst_id_instr",  id_instr, 32'd0);
        check32("rst_id_pc",     id_pc, 32'd0);
        check32("rst_id_pc4",    id_pc4, 32'd4);
        rst = 1'b0;
        m_pc = RESET_PC; m_occ = 0; m_drop = 1'b0; mem_pend = 1'b0;
        exp_q.delete();
        vis = 1'b0;
        mon_en = 1'b1;
    endtask

    // lat < 0 selects random latency; redir_div == 0 disables redirects.
    task automatic run(input int cycles, input int lat, input int ready_pct, input int redir_div);
        bit         real_ack, push, byp, take;
        ifq_entry_t e;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (imem_req) begin
                if (!mem_pend) begin
                    check32("req_addr", imem_addr, m_pc);
                    mem_pend = 1'b1;
                    mem_addr = imem_addr;
                    mem_lat  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
                end else begin
                    check32("addr_hold", imem_addr, mem_addr);
                end
            end
            check32("req_level", {31'b0, imem_req}, {31'b0, (m_occ < DEPTH)});

            real_ack = 1'b0;
            if (mem_pend && mem_lat == 0) real_ack = 1'b1;
            else if (mem_pend) mem_lat--;
            // Stray acks with no request outstanding must be ignored.
            imem_ack   = real_ack || (!imem_req && ($urandom_range(0, 7) == 0));
            imem_rdata = $urandom;
            redirect   = (redir_div != 0) && ($urandom_range(0, redir_div - 1) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           redirect_pc = $urandom;
            id_ready   = ($urandom_range(0, 99) < ready_pct);

            push = real_ack && !redirect && !m_drop;
            byp  = BYP && push && (m_occ == 0);
            vis  = !redirect && (m_occ > 0 || byp);
            take = vis && id_ready;
            if (redirect) exp_q.delete();
            if (push) begin
                e.pc = mem_addr; e.instr = imem_rdata;
                exp_q.push_back(e);
            end

            if (real_ack) begin
                mem_pend = 1'b0;
                if (redirect)    begin m_pc = redirect_pc & 32'hFFFF_FFFC; m_drop = 1'b0; end
                else if (m_drop) m_drop = 1'b0;
                else             m_pc = mem_addr + 32'd4;
            end else if (redirect) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                if (mem_pend) m_drop = 1'b1;
            end

            if (redirect) m_occ = 0;
            else          m_occ = m_occ + int'(push) - int'(take);
        end
    endtask

    // Monitor: compares the presented head against the oldest expected entry.
    initial begin
        ifq_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (mon_en) begin
                check32("id_valid", {31'b0, id_valid}, {31'b0, vis});
                if (id_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got pc %h, expected no entry", id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check32("id_pc",    id_pc,    e.pc);
                        check32("id_instr", id_instr, e.instr);
                        check32("id_pc4",   id_pc4,   e.pc + 32'd4);
                    end
                end
            end
        end
    end

    initial begin
        do_reset();
        run(60, 2, 100, 0);      // steady streaming, fixed latency
        run(40, -1, 0, 0);       // downstream stalled: queue fills, fetch holds
        run(30, -1, 100, 0);     // drain and restart
        run(3000, -1, 60, 12);   // mixed redirects, stalls and latencies
        run(500, -1, 20, 6);     // frequent redirects against a mostly full queue
        do_reset();
        run(1500, -1, 70, 10);
        done = 1'b1;
        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction prefetch queue between instruction memory and the IF stage of the five-stage pipeline. Issues sequential word fetches to a variable-latency instruction memory and buffers returned {pc, instr} pairs in a small FIFO. Hands entries to IF/ID through a valid/ready handshake. Flushes and restarts on a branch/jump redirect from downstream.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  word-aligned fetch address; stable while imem_req
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced 0
- id_valid  out  1  head entry available
- id_ready  in  1  IF/ID accepts head this cycle
- id_instr  out  32  head instruction
- id_pc  out  32  address of head instruction
- id_pc4  out  32  id_pc + 4, mod 2^32

## Operation
- Reset: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc4=4, occupancy=0, state=FETCH, fetch_pc=RESET_PC.
- FSM states:
  - FETCH: imem_req=1 at fetch_pc.
  - HOLD: queue full, imem_req=0.
  - DRAIN: discard the outstanding response after a redirect.
- FETCH, imem_ack, no redirect:
  - push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps 32'hFFFF_FFFC→0).
  - Next state FETCH if post-cycle occupancy < DEPTH, else HOLD.
- HOLD → FETCH in the cycle after occupancy drops below DEPTH.
- Pop when id_valid && id_ready. Push and pop in the same cycle leave occupancy unchanged, including when full.
- Redirect has highest priority:
  - Queue flushed at the clock edge; id_valid forced 0 combinationally during the redirect cycle.
  - Any pop that cycle is ignored.
  - fetch_pc ← redirect_pc.
- Redirect in FETCH without imem_ack → DRAIN. imem_req and imem_addr stay unchanged until imem_ack. The ack's data is dropped, then → FETCH at redirect_pc.
- Redirect in FETCH with imem_ack in the same cycle: data dropped; → FETCH at redirect_pc.
- Redirect in DRAIN: retarget fetch_pc; stay DRAIN.
- Redirect in HOLD: → FETCH at redirect_pc.
- At most one memory transaction outstanding.
- imem_ack is ignored when no request is outstanding.

## Timing
- Latency from imem_ack in cycle N:
  - queue empty: id_valid=1 in cycle N+1 (bypass disabled).
  - otherwise: entry appears after older entries.
- Next imem_req after an ack: cycle N+1 if space, i.e. back-to-back requests with one idle cycle of imem_req=0 never inserted.
- First imem_req: first cycle with rst=0.
- Redirect in cycle R:
  - DRAIN not entered: imem_req at redirect_pc in R+1.
  - DRAIN entered: imem_req at redirect_pc in the cycle after the draining ack.
- id_* outputs come from registered queue state (glitch-free). They hold stable while id_valid && !id_ready.
- rst mid-transaction: state reset immediately. A late imem_ack arriving while state=FETCH after reset is accepted as the response to the new request. The memory is reset together with this block.

## Configuration
- IFQ_BYPASS_EN defined:
  - Condition: queue empty, imem_ack=1, no redirect.
  - id_valid=1 combinationally in cycle N, with id_instr=imem_rdata, id_pc=fetch_pc, id_pc4=fetch_pc+4.
  - If id_ready, the entry is not pushed.
- IFQ_BYPASS_EN undefined: all responses pass through the FIFO; outputs are fully registered.

## Structure
- Package ifq_pkg:
  - enum ifq_state_t {FETCH, HOLD, DRAIN}.
  - struct ifq_entry_t {pc[31:0], instr[31:0]}.
  - localparam INSTR_BYTES=4.
- Sub-module ifq_fifo (DEPTH, ifq_entry_t):
  - Interface: push, pop, flush, head, occupancy, full, empty.
  - Pointers of log2(DEPTH) bits with an extra wrap bit.
- Top module: FSM, fetch_pc, output muxing.

## Test plan
- Reset, memory acks 2 cycles after each req, id_ready=1 → imem_addr 0,4,8,… Entries out in order with id_pc4 = id_pc+4.
- id_ready=0, DEPTH=4 → exactly 4 acks accepted; imem_req=0 (HOLD). One pop → imem_req=1 at addr 0x10 the next cycle.
- Redirect to 0x100 while a req at 0x8 is outstanding → req/addr 0x8 held until ack; data discarded; next req at 0x100. First delivered id_pc=0x100.
- Redirect coincident with imem_ack and a full queue with id_ready=1 → no pop counted, queue empty next cycle, next req at redirect_pc.
- fetch_pc=0xFFFF_FFFC → after ack, next imem_addr=0x0; id_pc4=0x0 for that entry.
- IFQ_BYPASS_EN, empty queue, ack with id_ready=1 → id_valid and id_instr=imem_rdata in the ack cycle; occupancy stays 0.
